uart_tx_pacer: RTL

Byte buffer and rate pacer between the echo/processing stage and uart_send. It accepts single-cycle byte strobes at any rate and stores them in a FIFO. It then re-issues them to uart_send as single-cycle valid pulses, spaced at least one full UART frame apart. uart_send has no ready/busy output, so this pacing is what prevents bytes being lost during a transmission.

---
 rtl/uart_pkg.sv | 22 ++
 rtl/sync_fifo.sv | 79 +++++++
 rtl/uart_tx_pacer.sv | 115 +++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared constants and types for the UART transmit path.
// Timing defaults assume a 100 MHz clock and 9600 baud.
package uart_pkg;

  localparam int BYTE_W          = 8;
  localparam int BIT_CYCLES_DFLT = 10417;
  localparam int FRAME_BITS_DFLT = 10;
  localparam int GAP_CYCLES_DFLT = 2;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    HOLD = 1'b1
  } pacer_state_e;

  // Number of clocks one frame, plus its trailing gap, keeps the line busy.
  function automatic int frame_cycles(input int bit_cycles,
                                      input int frame_bits,
                                      input int gap_cycles);
    return bit_cycles * frame_bits + gap_cycles;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock circular byte FIFO with an occupancy counter.
// The read head is shown combinationally on dout.
module sync_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic [BYTE_W-1:0] din,
  output logic [BYTE_W-1:0] dout,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   count
);

  localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0]   CNT_ONE = (ADDR_W + 1)'(1);
  localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1);

  logic [BYTE_W-1:0] mem_q [DEPTH];
  logic [ADDR_W-1:0] wptr_q, wptr_d;
  logic [ADDR_W-1:0] rptr_q, rptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              do_push_s;
  logic              do_pop_s;

  // A push into a full buffer is safe only when a pop frees the slot in the same cycle.
  assign do_pop_s  = pop && (count_q != {(ADDR_W + 1){1'b0}});
  assign do_push_s = push && ((count_q != DEPTH_C) || do_pop_s);

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (do_push_s) begin
      wptr_d = wptr_q + PTR_ONE;
    end else begin
      wptr_d = wptr_q;
    end
    if (do_pop_s) begin
      rptr_d = rptr_q + PTR_ONE;
    end else begin
      rptr_d = rptr_q;
    end
    case ({do_push_s, do_pop_s})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wptr_q  <= {ADDR_W{1'b0}};
      rptr_q  <= {ADDR_W{1'b0}};
      count_q <= {(ADDR_W + 1){1'b0}};
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_q[wptr_q] <= din;
    end
  end

  assign dout  = mem_q[rptr_q];
  assign full  = (count_q == DEPTH_C);
  assign empty = (count_q == {(ADDR_W + 1){1'b0}});
  assign count = count_q;

endmodule

// File: rtl/uart_tx_pacer.sv
// Buffers byte strobes and re-issues them to uart_send no faster than one
// frame apart, because uart_send has no busy indication of its own.
module uart_tx_pacer
  import uart_pkg::*;
#(
  parameter int DEPTH      = 16,
  parameter int ADDR_W     = 4,
  parameter int BIT_CYCLES = BIT_CYCLES_DFLT,
  parameter int FRAME_BITS = FRAME_BITS_DFLT,
  parameter int GAP_CYCLES = GAP_CYCLES_DFLT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [BYTE_W-1:0] in_data,
  output logic              out_valid,
  output logic [BYTE_W-1:0] out_data,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   count,
  output logic              overflow
);

  localparam int FRAME_CYCLES = frame_cycles(BIT_CYCLES, FRAME_BITS, GAP_CYCLES);
  localparam int CNT_W        = (FRAME_CYCLES > 1) ? $clog2(FRAME_CYCLES) : 1;
  localparam logic [CNT_W-1:0] FRAME_LOAD = CNT_W'(FRAME_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  pacer_state_e      state_q, state_d;
  logic [CNT_W-1:0]  frame_cnt_q, frame_cnt_d;
  logic              out_valid_q, out_valid_d;
  logic [BYTE_W-1:0] out_data_q, out_data_d;
  logic              overflow_q, overflow_d;

  logic              fifo_push_s;
  logic              fifo_pop_s;
  logic [BYTE_W-1:0] fifo_dout_s;
  logic              fifo_full_s;
  logic              fifo_empty_s;
  logic [ADDR_W:0]   fifo_count_s;

  assign fifo_pop_s  = (state_q == IDLE) && !fifo_empty_s;
  assign fifo_push_s = in_valid && (!fifo_full_s || fifo_pop_s);

  sync_fifo #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push_s),
    .pop   (fifo_pop_s),
    .din   (in_data),
    .dout  (fifo_dout_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s),
    .count (fifo_count_s)
  );

  // IDLE launches the head byte; HOLD counts out one frame plus gap before the next launch.
  always_comb begin
    state_d     = state_q;
    frame_cnt_d = frame_cnt_q;
    out_valid_d = 1'b0;
    out_data_d  = out_data_q;
    overflow_d  = in_valid && fifo_full_s && !fifo_pop_s;
    case (state_q)
      IDLE: begin
        if (!fifo_empty_s) begin
          state_d     = HOLD;
          frame_cnt_d = FRAME_LOAD;
          out_valid_d = 1'b1;
          out_data_d  = fifo_dout_s;
        end else begin
          state_d = IDLE;
        end
      end
      HOLD: begin
        if (frame_cnt_q == {CNT_W{1'b0}}) begin
          state_d = IDLE;
        end else begin
          frame_cnt_d = frame_cnt_q - CNT_ONE;
        end
      end
      default: begin
        state_d     = IDLE;
        frame_cnt_d = {CNT_W{1'b0}};
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      frame_cnt_q <= {CNT_W{1'b0}};
      out_valid_q <= 1'b0;
      out_data_q  <= {BYTE_W{1'b0}};
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      frame_cnt_q <= frame_cnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      overflow_q  <= overflow_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign overflow  = overflow_q;
  assign full      = fifo_full_s;
  assign empty     = fifo_empty_s;
  assign count     = fifo_count_s;

endmodule
